// File: rtl/alu_ctrl_muldiv.sv
// MIPS EX-stage ALU control: decodes ALUOp/funct into the main-ALU select and runs
// an iterative multiply/divide engine that owns the HI/LO registers.
module alu_ctrl_muldiv #(
    parameter int W     = 32,
    parameter bit MD_EN = 1'b1
) (
    input  logic         Clk,
    input  logic         RstN,
    input  logic         Start,
    input  logic [2:0]   Code,
    input  logic [5:0]   Ins,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [2:0]   OutAlu,
    output logic         IllegalOp,
    output logic         Stall,
    output logic         Busy,
    output logic         Done,
    output logic         DivZero,
    output logic [W-1:0] HiLoOut,
    output logic [W-1:0] Hi,
    output logic [W-1:0] Lo
);
    localparam int CW = $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          op_div, neg_q, neg_r, bz;
    logic [W-1:0]  acc, mq, bmag, a_raw;

    logic md_op, go_op, is_mthi, is_mtlo, is_mfhi;

    // md_op marks every funct that touches the engine or HI/LO; these are the ones that stall
    always_comb begin
        OutAlu    = 3'd0;
        IllegalOp = 1'b0;
        md_op     = 1'b0;
        go_op     = 1'b0;
        is_mthi   = 1'b0;
        is_mtlo   = 1'b0;
        is_mfhi   = 1'b0;
        case (Code)
            3'b000: OutAlu = 3'd0;
            3'b010: OutAlu = 3'd1;
            3'b001: begin
                case (Ins)
                    6'b100000: OutAlu = 3'd0;
                    6'b100010: OutAlu = 3'd1;
                    6'b100100: OutAlu = 3'd2;
                    6'b100101: OutAlu = 3'd3;
                    6'b101010: OutAlu = 3'd4;
                    6'b100111: OutAlu = 3'd5;
                    6'b100110: OutAlu = 3'd6;
                    6'b010000, 6'b010010: begin
                        if (MD_EN) begin
                            OutAlu  = 3'd7;
                            md_op   = 1'b1;
                            is_mfhi = (Ins == 6'b010000);
                        end else begin
                            IllegalOp = 1'b1;
                        end
                    end
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                        if (MD_EN) begin
                            md_op = 1'b1;
                            go_op = 1'b1;
                        end else begin
                            IllegalOp = 1'b1;
                        end
                    end
                    6'b010001, 6'b010011: begin
                        if (MD_EN) begin
                            md_op   = 1'b1;
                            is_mthi = (Ins == 6'b010001);
                            is_mtlo = (Ins == 6'b010011);
                        end else begin
                            IllegalOp = 1'b1;
                        end
                    end
                    default: IllegalOp = 1'b1;
                endcase
            end
            default: IllegalOp = 1'b1;
        endcase
    end

    assign Busy    = (state == S_RUN) || (state == S_FIX);
    assign Done    = (state == S_DONE);
    assign Stall   = Start && Busy && md_op;
    assign HiLoOut = is_mfhi ? Hi : Lo;

    logic accept;
    assign accept = Start && !Busy && !IllegalOp;

    // Operands enter the engine as magnitudes; signs are reapplied in FIX
    logic         sgn, sa, sb;
    logic [W-1:0] amag, bin_mag;
    always_comb begin
        sgn     = !Ins[0];
        sa      = sgn & A[W-1];
        sb      = sgn & B[W-1];
        amag    = sa ? -A : A;
        bin_mag = sb ? -B : B;
    end

    logic [W:0] addend, msum, shifted, diff;
    always_comb begin
        addend  = mq[0] ? {1'b0, bmag} : {(W+1){1'b0}};
        msum    = {1'b0, acc} + addend;
        shifted = {acc, mq[W-1]};
        diff    = shifted - {1'b0, bmag};
    end

    logic [2*W-1:0] prod, prod_fix;
    logic [W-1:0]   fix_hi, fix_lo;
    always_comb begin
        prod     = {acc, mq};
        prod_fix = neg_q ? -prod : prod;
        if (!op_div) begin
            fix_hi = prod_fix[2*W-1:W];
            fix_lo = prod_fix[W-1:0];
        end else if (bz) begin
            fix_hi = a_raw;
            fix_lo = '1;
        end else begin
            fix_hi = neg_r ? -acc : acc;
            fix_lo = neg_q ? -mq : mq;
        end
    end

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            state   <= S_IDLE;
            cnt     <= '0;
            Hi      <= '0;
            Lo      <= '0;
            DivZero <= 1'b0;
            op_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            bz      <= 1'b0;
            acc     <= '0;
            mq      <= '0;
            bmag    <= '0;
            a_raw   <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (op_div) begin
                        // restoring step: borrow in bit W means the trial subtract failed
                        if (!diff[W]) begin
                            acc <= diff[W-1:0];
                            mq  <= {mq[W-2:0], 1'b1};
                        end else begin
                            acc <= shifted[W-1:0];
                            mq  <= {mq[W-2:0], 1'b0};
                        end
                    end else begin
                        acc <= msum[W:1];
                        mq  <= {msum[0], mq[W-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W-1)) state <= S_FIX;
                end
                S_FIX: begin
                    Hi      <= fix_hi;
                    Lo      <= fix_lo;
                    DivZero <= op_div && bz;
                    state   <= S_DONE;
                end
                default: begin
                    if (accept && go_op) begin
                        op_div <= Ins[1];
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa;
                        bz     <= (B == '0);
                        a_raw  <= A;
                        acc    <= '0;
                        mq     <= amag;
                        bmag   <= bin_mag;
                        cnt    <= '0;
                        state  <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
            if (accept && is_mthi) Hi <= A;
            if (accept && is_mtlo) Lo <= A;
        end
    end
endmodule
